// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined RV32I control unit: opcodes, field
// encodings, the per-stage control word and the hazard/forwarding helpers.
package pipe_ctrl_pkg;

    // Register fields travel at this width and are narrowed to RA_W at the ports.
    localparam int RA_MAX = 8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ALU_R    = 3'b000,
        ALU_I    = 3'b001,
        ALU_S    = 3'b010,
        ALU_B    = 3'b011,
        ALU_U    = 3'b100,
        ALU_JAL  = 3'b101,
        ALU_LOAD = 3'b111
    } aluop_e;

    typedef enum logic [1:0] {
        DSEL_PC4 = 2'b00,
        DSEL_IMM = 2'b01,
        DSEL_ALU = 2'b10,
        DSEL_MEM = 2'b11
    } dsel_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_e;

    typedef struct packed {
        logic              valid;
        logic              jal;
        logic              jalr;
        logic              branch;
        logic              alusrc1;
        logic              alusrc2;
        aluop_e            aluop;
        logic              memread;
        logic              memwrite;
        logic              regwrite;
        dsel_e             data_sel;
        logic [RA_MAX-1:0] rs1;
        logic [RA_MAX-1:0] rs2;
        logic [RA_MAX-1:0] rd;
        logic              uses_rs1;
        logic              uses_rs2;
    } ctrl_t;

    // x0 is never a real producer, so it can neither stall nor be forwarded.
    function automatic logic writes_src(ctrl_t w, logic [RA_MAX-1:0] src);
        return w.valid && w.regwrite && (w.rd != '0) && (w.rd == src);
    endfunction

    function automatic logic reads_result(ctrl_t producer, ctrl_t consumer);
        return (consumer.uses_rs1 && writes_src(producer, consumer.rs1)) ||
               (consumer.uses_rs2 && writes_src(producer, consumer.rs2));
    endfunction

    function automatic fwd_e fwd_select(ctrl_t exmem, ctrl_t memwb, logic [RA_MAX-1:0] src);
        if (writes_src(exmem, src))
            return FWD_EXMEM;
        else if (writes_src(memwb, src))
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode-to-control-word decoder for the ID stage.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            i_valid,
    input  logic [6:0]      i_opcode,
    input  logic [RA_W-1:0] i_rs1,
    input  logic [RA_W-1:0] i_rs2,
    input  logic [RA_W-1:0] i_rd,
    output ctrl_t           o_ctrl
);

    always_comb begin
        o_ctrl          = '0;
        o_ctrl.valid    = i_valid;
        o_ctrl.rs1      = RA_MAX'(i_rs1);
        o_ctrl.rs2      = RA_MAX'(i_rs2);
        o_ctrl.rd       = RA_MAX'(i_rd);
        o_ctrl.aluop    = ALU_R;
        o_ctrl.data_sel = DSEL_ALU;
        // Unrecognised opcodes fall through with every enable left at 0.
        case (i_opcode)
            OP_R: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.uses_rs1 = 1'b1;
                o_ctrl.uses_rs2 = 1'b1;
            end
            OP_I: begin
                o_ctrl.aluop    = ALU_I;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc2  = 1'b1;
                o_ctrl.uses_rs1 = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl.aluop    = ALU_LOAD;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc2  = 1'b1;
                o_ctrl.memread  = 1'b1;
                o_ctrl.data_sel = DSEL_MEM;
                o_ctrl.uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.aluop    = ALU_S;
                o_ctrl.alusrc2  = 1'b1;
                o_ctrl.memwrite = 1'b1;
                o_ctrl.uses_rs1 = 1'b1;
                o_ctrl.uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.aluop    = ALU_B;
                o_ctrl.branch   = 1'b1;
                o_ctrl.uses_rs1 = 1'b1;
                o_ctrl.uses_rs2 = 1'b1;
            end
            OP_LUI: begin
                o_ctrl.aluop    = ALU_U;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.data_sel = DSEL_IMM;
            end
            OP_AUIPC: begin
                o_ctrl.aluop    = ALU_U;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc1  = 1'b1;
                o_ctrl.alusrc2  = 1'b1;
            end
            OP_JAL: begin
                o_ctrl.aluop    = ALU_JAL;
                o_ctrl.jal      = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.data_sel = DSEL_PC4;
            end
            OP_JALR: begin
                o_ctrl.aluop    = ALU_I;
                o_ctrl.jalr     = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.data_sel = DSEL_PC4;
                o_ctrl.uses_rs1 = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: carries the decoded control word through ID/EX,
// EX/MEM and MEM/WB and produces stall, flush and forwarding selects.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int RA_W   = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_id_valid,
    input  logic [6:0]      i_id_opcode,
    input  logic [RA_W-1:0] i_id_rs1,
    input  logic [RA_W-1:0] i_id_rs2,
    input  logic [RA_W-1:0] i_id_rd,
    input  logic            i_ex_redirect,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_ex_valid,
    output logic            o_ex_jal,
    output logic            o_ex_jalr,
    output logic            o_ex_branch,
    output logic            o_ex_alusrc1,
    output logic            o_ex_alusrc2,
    output logic [2:0]      o_ex_aluop,
    output logic [1:0]      o_fwd_a,
    output logic [1:0]      o_fwd_b,
    output logic            o_mem_valid,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_wb_valid,
    output logic            o_wb_regwrite,
    output logic [RA_W-1:0] o_wb_rd,
    output logic [1:0]      o_wb_data_sel
);

    ctrl_t id_ctrl;
    ctrl_t idex_q, idex_d;
    ctrl_t exmem_q;
    ctrl_t memwb_q;
    logic  hazard;
    logic  unused_memwb;

    ctrl_decode #(.RA_W(RA_W)) u_decode (
        .i_valid  (i_id_valid),
        .i_opcode (i_id_opcode),
        .i_rs1    (i_id_rs1),
        .i_rs2    (i_id_rs2),
        .i_rd     (i_id_rd),
        .o_ctrl   (id_ctrl)
    );

    generate
        if (FWD_EN) begin : g_fwd
            // Only a load in EX cannot be bypassed in time for the next EX.
            assign hazard  = idex_q.memread && reads_result(idex_q, id_ctrl);
            assign o_fwd_a = fwd_select(exmem_q, memwb_q, idex_q.rs1);
            assign o_fwd_b = fwd_select(exmem_q, memwb_q, idex_q.rs2);
        end else begin : g_nofwd
            // MEM/WB is covered by the register file's write-through.
            assign hazard  = reads_result(idex_q, id_ctrl) || reads_result(exmem_q, id_ctrl);
            assign o_fwd_a = FWD_RF;
            assign o_fwd_b = FWD_RF;
        end
    endgenerate

    assign o_flush = i_ex_redirect && idex_q.valid && !i_rst;
    assign o_stall = id_ctrl.valid && hazard && !o_flush && !i_rst;

    always_comb begin
        idex_d = id_ctrl;
        if (!id_ctrl.valid || o_stall || o_flush)
            idex_d = '0;
    end

    // The redirecting instruction itself still advances, so its link write survives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= idex_q;
            memwb_q <= exmem_q;
        end
    end

    assign o_ex_valid    = idex_q.valid;
    assign o_ex_jal      = idex_q.jal;
    assign o_ex_jalr     = idex_q.jalr;
    assign o_ex_branch   = idex_q.branch;
    assign o_ex_alusrc1  = idex_q.alusrc1;
    assign o_ex_alusrc2  = idex_q.alusrc2;
    assign o_ex_aluop    = idex_q.aluop;
    assign o_mem_valid   = exmem_q.valid;
    assign o_mem_read    = exmem_q.memread;
    assign o_mem_write   = exmem_q.memwrite;
    assign o_wb_valid    = memwb_q.valid;
    assign o_wb_regwrite = memwb_q.regwrite;
    assign o_wb_rd       = memwb_q.rd[RA_W-1:0];
    assign o_wb_data_sel = memwb_q.data_sel;

    assign unused_memwb = ^memwb_q;

endmodule
